// File: rtl/sensor_tx_scheduler.sv
// Arbitrates ADS1292 sample frames and MPR121 touch changes onto one 32-bit UART TX word stream.
// Optional SENSOR_TX_DROP_CNT_EN adds a saturating dropped-ADS-frame counter port.
module sensor_tx_scheduler #(
  parameter logic [7:0] ADS_TAG = 8'hA0,
  parameter logic [7:0] MPR_TAG = 8'hB0
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic        i_RUN_SET,
  input  logic [71:0] i_ADS1292_DATA_OUT,
  input  logic        i_ADS1292_DATA_READY,
  input  logic [11:0] i_MPR121_TOUCH_STATUS,
  output logic [31:0] o_UART_DATA_TX,
  output logic        o_UART_DATA_TX_VALID,
  input  logic        i_UART_DATA_TX_READY,
  output logic        o_BUSY
`ifdef SENSOR_TX_DROP_CNT_EN
  ,
  output logic [7:0]  o_ADS_DROP_CNT
`endif
);

  typedef enum logic [2:0] {IDLE, ADS0, ADS1, ADS2, MPR} state_t;

  state_t      state, state_nxt;
  logic        ads_pend, mpr_pend, last_was_ads;
  logic [11:0] mpr_last;
  logic [71:0] ads_buf, ads_sh;
  logic [11:0] mpr_buf, mpr_sh;

  logic ads_cap, mpr_cap, ads_avail, mpr_avail;
  logic take_ads, take_mpr, hs, ads_drop;

  assign ads_cap   = i_ADS1292_DATA_READY & i_RUN_SET;
  assign mpr_cap   = i_RUN_SET & (i_MPR121_TOUCH_STATUS != mpr_last);
  // A capture arriving while IDLE is forwarded straight into the shadow, giving one-cycle latency.
  assign ads_avail = i_RUN_SET & (ads_pend | i_ADS1292_DATA_READY);
  assign mpr_avail = i_RUN_SET & (mpr_pend | mpr_cap);
  assign hs        = o_UART_DATA_TX_VALID & i_UART_DATA_TX_READY;
  assign ads_drop  = ads_cap & ads_pend & ~take_ads;

  always_comb begin
    state_nxt = state;
    take_ads  = 1'b0;
    take_mpr  = 1'b0;
    case (state)
      IDLE: begin
        if (ads_avail && (!last_was_ads || !mpr_avail)) begin
          state_nxt = ADS0;
          take_ads  = 1'b1;
        end else if (mpr_avail) begin
          state_nxt = MPR;
          take_mpr  = 1'b1;
        end
      end
      ADS0:    if (hs) state_nxt = ADS1;
      ADS1:    if (hs) state_nxt = ADS2;
      ADS2:    if (hs) state_nxt = IDLE;
      MPR:     if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state        <= IDLE;
      ads_pend     <= 1'b0;
      mpr_pend     <= 1'b0;
      last_was_ads <= 1'b0;
      mpr_last     <= 12'h000;
    end else begin
      state <= state_nxt;
      if (take_ads)
        last_was_ads <= 1'b1;
      else if (take_mpr)
        last_was_ads <= 1'b0;
      // Consumption clears the old flag; a same-cycle capture re-arms it unless it was forwarded.
      if (!i_RUN_SET)
        ads_pend <= 1'b0;
      else if (ads_cap)
        ads_pend <= ads_pend | ~take_ads;
      else if (take_ads)
        ads_pend <= 1'b0;
      if (!i_RUN_SET)
        mpr_pend <= 1'b0;
      else if (mpr_cap)
        mpr_pend <= mpr_pend | ~take_mpr;
      else if (take_mpr)
        mpr_pend <= 1'b0;
      if (mpr_cap)
        mpr_last <= i_MPR121_TOUCH_STATUS;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (ads_cap && (!ads_pend || take_ads))
      ads_buf <= i_ADS1292_DATA_OUT;
    if (mpr_cap)
      mpr_buf <= i_MPR121_TOUCH_STATUS;
    if (take_ads)
      ads_sh <= ads_pend ? ads_buf : i_ADS1292_DATA_OUT;
    if (take_mpr)
      mpr_sh <= mpr_pend ? mpr_buf : i_MPR121_TOUCH_STATUS;
  end

  always_comb begin
    o_UART_DATA_TX = 32'h0;
    case (state)
      ADS0:    o_UART_DATA_TX = {ADS_TAG,         ads_sh[71:48]};
      ADS1:    o_UART_DATA_TX = {ADS_TAG + 8'd1,  ads_sh[47:24]};
      ADS2:    o_UART_DATA_TX = {ADS_TAG + 8'd2,  ads_sh[23:0]};
      MPR:     o_UART_DATA_TX = {MPR_TAG, 12'h000, mpr_sh};
      default: o_UART_DATA_TX = 32'h0;
    endcase
  end

  assign o_UART_DATA_TX_VALID = (state != IDLE);
  assign o_BUSY               = (state != IDLE) | ads_pend | mpr_pend;

`ifdef SENSOR_TX_DROP_CNT_EN
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN)
      o_ADS_DROP_CNT <= 8'h00;
    else if (ads_drop && o_ADS_DROP_CNT != 8'hFF)
      o_ADS_DROP_CNT <= o_ADS_DROP_CNT + 8'd1;
  end
`else
  logic drop_unused;
  assign drop_unused = ads_drop;
`endif

endmodule

// File: tb/tb_sensor_tx_scheduler.sv
// Scoreboard bench for sensor_tx_scheduler: expected words queued at stimulus, popped on each handshake.
module tb_sensor_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [71:0] ads_data = '0;
  logic        ads_rdy = 1'b0;
  logic [11:0] touch = '0;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
`ifdef SENSOR_TX_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];

  sensor_tx_scheduler dut (
    .i_CLK                 (clk),
    .i_RSTN                (rst_n),
    .i_RUN_SET             (run),
    .i_ADS1292_DATA_OUT    (ads_data),
    .i_ADS1292_DATA_READY  (ads_rdy),
    .i_MPR121_TOUCH_STATUS (touch),
    .o_UART_DATA_TX        (tx_data),
    .o_UART_DATA_TX_VALID  (tx_valid),
    .i_UART_DATA_TX_READY  (tx_ready),
    .o_BUSY                (busy)
`ifdef SENSOR_TX_DROP_CNT_EN
    ,
    .o_ADS_DROP_CNT        (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      if (sb.size() > 0) begin
        automatic logic [31:0] e = sb.pop_front();
        chk("word", tx_data, e);
      end else begin
        chk("extra_word", tx_data, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ads(input logic [71:0] f);
    sb.push_back({8'hA0, f[71:48]});
    sb.push_back({8'hA1, f[47:24]});
    sb.push_back({8'hA2, f[23:0]});
  endtask

  task automatic pulse_ads(input logic [71:0] f);
    ads_data = f;
    ads_rdy  = 1'b1;
    tick();
    ads_rdy  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    chk("drain", sb.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_data", tx_data, 32'h0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
`ifdef SENSOR_TX_DROP_CNT_EN
    chk("rst_drop", drop_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b1; tx_ready = 1'b1;
    tick();

    // Single ADS frame, one-cycle latency
    push_ads(72'h112233_445566_778899);
    ads_data = 72'h112233_445566_778899;
    ads_rdy  = 1'b1;
    @(negedge clk);
    chk("lat_idle", tx_valid, 0);
    @(posedge clk); #1;
    ads_rdy = 1'b0;
    @(negedge clk);
    chk("lat_valid", tx_valid, 1);
    chk("lat_word", tx_data, 32'hA0112233);
    wait_drain(20);
    chk("idle_busy", busy, 0);

    // MPR changes; a held value produces nothing further
    touch = 12'h005;
    sb.push_back(32'hB0000005);
    repeat (12) tick();
    wait_drain(5);
    touch = 12'h0A3;
    sb.push_back(32'hB00000A3);
    wait_drain(10);
    touch = 12'h000;
    sb.push_back(32'hB0000000);
    wait_drain(10);

    // Fairness: ADS packet, MPR word, ADS packet
    push_ads(72'hF1F1F1_E1E1E1_D1D1D1);
    sb.push_back(32'hB0000007);
    push_ads(72'hF2F2F2_E2E2E2_D2D2D2);
    touch = 12'h007;
    pulse_ads(72'hF1F1F1_E1E1E1_D1D1D1);
    pulse_ads(72'hF2F2F2_E2E2E2_D2D2D2);
    wait_drain(30);

    // Backpressure during ADS1
    push_ads(72'hCAFE01_BEEF02_D00D03);
    pulse_ads(72'hCAFE01_BEEF02_D00D03);
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", tx_valid, 1);
      chk("hold_data", tx_data, 32'hA1BEEF02);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_drain(20);

    // Three frames while stalled: first sent, second held, third dropped
    tx_ready = 1'b0;
    push_ads(72'h010101_020202_030303);
    push_ads(72'h111111_121212_131313);
    pulse_ads(72'h010101_020202_030303);
    pulse_ads(72'h111111_121212_131313);
    pulse_ads(72'h212121_222222_232323);
    @(negedge clk);
    chk("stall_busy", busy, 1);
`ifdef SENSOR_TX_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, 1);
`endif
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_drain(30);

    // Reset asserted during ADS1
    sb.push_back(32'hA0ABCDEF);
    pulse_ads(72'hABCDEF_123456_654321);
    tick();
    tx_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    touch = 12'h000;
    #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_data", tx_data, 32'h0);
    chk("mid_rst_busy", busy, 0);
`ifdef SENSOR_TX_DROP_CNT_EN
    chk("mid_rst_drop", drop_cnt, 0);
`endif
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", tx_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
